coeff_recomposer: RTL and testbench

Pipelined inverse of the coefficient decomposer. Takes a low-part/high-part pair (r0 in [0,q) representation, r1) and rebuilds r = (r1·α + r0) mod q with α = 2·γ2. A decompose→recompose chain reproduces the original coefficient bit-exactly, including the r − r0 = q−1 corner. Sits in the same streaming datapath as the decomposer, with the same valid/ready convention. Used by the verify path and by the self-check bench.

---
 rtl/dilithium_pkg.sv | 21 ++
 rtl/decomp_alpha_mult.sv | 26 ++
 rtl/coeff_recomposer.sv | 90 +++++++++
 tb/tb_coeff_recomposer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants for the coefficient decompose/recompose datapath.
package dilithium_pkg;
  localparam int COEFF_W = 24;
  localparam int R1_W    = 6;
  localparam int PROD_W  = 23;
  localparam int LVL_W   = 3;

  localparam logic [COEFF_W-1:0] Q = 24'd8380417;

  localparam int ALPHA_L2  = 190464;
  localparam int ALPHA_L35 = 523776;

  localparam logic [R1_W-1:0] R1_MAX_L2  = 6'd43;
  localparam logic [R1_W-1:0] R1_MAX_L35 = 6'd15;

  localparam logic [LVL_W-1:0] LVL_2 = 3'd2;

  function automatic logic r1_out_of_range(input logic [R1_W-1:0] r1, input logic lvl2);
    return r1 > (lvl2 ? R1_MAX_L2 : R1_MAX_L35);
  endfunction
endpackage

// File: rtl/decomp_alpha_mult.sv
// Registered shift-add multiply of r1 by alpha = 2*gamma2 (one cycle latency).
module decomp_alpha_mult
  import dilithium_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [R1_W-1:0]   dib,
  input  logic              lvl2,
  output logic [PROD_W-1:0] p
);
  logic [PROD_W-1:0] b;
  logic [PROD_W-1:0] sum;

  // NOTE: assign every always_comb output on every path so no latch is inferred.
  always_comb begin
    b = {{(PROD_W - R1_W){1'b0}}, dib};
    if (lvl2) sum = (b << 17) + (b << 16) - (b << 12) - (b << 11);
    else      sum = (b << 19) - (b << 9);
  end

  // NOTE: state uses non-blocking assignments; data registers carry no reset,
  // only the valid bits (and visible outputs) need a defined reset value.
  always_ff @(posedge clk) begin
    if (en) p <= sum;
  end
endmodule

// File: rtl/coeff_recomposer.sv
// Four-stage pipeline rebuilding r = (r1*alpha + r0) mod q from a decomposed pair.
// Optional error flag for out-of-range pairs: define COEFF_RECOMP_RANGE_CHECK_EN.
module coeff_recomposer
  import dilithium_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_i,
  input  logic [LVL_W-1:0]   sec_lvl,
  input  logic [COEFF_W-1:0] dia,
  input  logic [R1_W-1:0]    dib,
  output logic [COEFF_W-1:0] dout,
  output logic               valid_o,
  input  logic               ready_o,
  output logic               busy
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
  ,
  output logic               err_o
`endif
);
  logic                en;
  logic [3:0]          vld;
  logic [COEFF_W-1:0]  dia_s1;
  logic [R1_W-1:0]     dib_s1;
  logic [LVL_W-1:0]    lvl_s1;
  logic                lvl2_s1;
  logic [COEFF_W-1:0]  dia_s2;
  logic [PROD_W-1:0]   p_s2;
  logic [COEFF_W:0]    s_s3;
  logic [COEFF_W-1:0]  s_red;

  // ready_o is the global pipeline enable; upstream sees it unchanged.
  assign en      = ready_o;
  assign ready_i = ready_o;

  always_ff @(posedge clk) begin
    if (rst)     vld <= '0;
    else if (en) vld <= {vld[2:0], valid_i};
  end

  assign valid_o = vld[3];
  assign busy    = |vld;

  always_ff @(posedge clk) begin
    if (en) begin
      dia_s1 <= dia;
      dib_s1 <= dib;
      lvl_s1 <= sec_lvl;
      dia_s2 <= dia_s1;
      s_s3   <= {2'b00, p_s2} + {1'b0, dia_s2};
    end
  end

  assign lvl2_s1 = (lvl_s1 == LVL_2);

  decomp_alpha_mult u_mult (
    .clk  (clk),
    .en   (en),
    .dib  (dib_s1),
    .lvl2 (lvl2_s1),
    .p    (p_s2)
  );

  // s < 2q for in-range pairs, so s - q fits the coefficient width.
  assign s_red = s_s3[COEFF_W-1:0] - Q;

  always_ff @(posedge clk) begin
    if (rst)     dout <= '0;
    else if (en) dout <= (s_s3 >= {1'b0, Q}) ? s_red : s_s3[COEFF_W-1:0];
  end

`ifdef COEFF_RECOMP_RANGE_CHECK_EN
  logic err_s2;
  logic err_s3;

  always_ff @(posedge clk) begin
    if (en) begin
      err_s2 <= r1_out_of_range(dib_s1, lvl2_s1) || (dia_s1 >= Q);
      err_s3 <= err_s2;
    end
  end

  // Gated by the valid bit so bubbles never raise the flag.
  always_ff @(posedge clk) begin
    if (rst)     err_o <= 1'b0;
    else if (en) err_o <= err_s3 & vld[2];
  end
`endif
endmodule

// File: tb/tb_coeff_recomposer.sv
// Scoreboard bench for coeff_recomposer: directed cases, round trip, stall and reset.
module tb_coeff_recomposer;
  localparam int TQ  = 8380417;
  localparam int TA2 = 190464;
  localparam int TA5 = 523776;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic [2:0]  sec_lvl;
  logic [23:0] dia;
  logic [5:0]  dib;
  logic [23:0] dout;
  logic        valid_o;
  logic        ready_o;
  logic        busy;
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
  logic        err_o;
`endif

  typedef struct packed {
    logic [23:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  coeff_recomposer dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_i (ready_i),
    .sec_lvl (sec_lvl),
    .dia     (dia),
    .dib     (dib),
    .dout    (dout),
    .valid_o (valid_o),
    .ready_o (ready_o),
    .busy    (busy)
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
    ,
    .err_o   (err_o)
`endif
  );

  function automatic logic [23:0] model(input logic [23:0] a, input logic [5:0] b,
                                        input logic [2:0] lvl);
    longint al;
    al = (lvl == 3'd2) ? longint'(TA2) : longint'(TA5);
    return 24'((longint'(b) * al + longint'(a)) % longint'(TQ));
  endfunction

  // Reference decomposer: r0 centred in (-alpha/2, alpha/2], with the q-1 corner.
  function automatic void decompose(input int r, input bit l2, output int r0q, output int r1);
    int a;
    int r0;
    a  = l2 ? TA2 : TA5;
    r0 = r % a;
    if (r0 > a / 2) r0 -= a;
    if (r - r0 == TQ - 1) begin
      r1 = 0;
      r0 -= 1;
    end else begin
      r1 = (r - r0) / a;
    end
    r0q = (r0 < 0) ? r0 + TQ : r0;
  endfunction

  task automatic drive(input logic v, input logic rdy, input logic [23:0] a,
                       input logic [5:0] b, input logic [2:0] lvl, input logic [23:0] exp_do);
    exp_t e;
    logic oor;
    oor = (b > ((lvl == 3'd2) ? 6'd43 : 6'd15)) || (a >= 24'(TQ));
    e.data = exp_do;
    e.chk_data = !oor;
    e.err = oor;
    valid_i = v;
    ready_o = rdy;
    dia = a;
    dib = b;
    sec_lvl = lvl;
    if (v && rdy) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, rdy, 24'd0, 6'd0, 3'd2, 24'd0);
  endtask

  // Output consumed at the next edge when valid_o & ready_o; sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output got do=%0d, required no output", dout);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_data) begin
          n_vec++;
          if (dout !== mon_e.data) begin
            n_err++;
            $display("FAIL do got %0d, required %0d", dout, mon_e.data);
          end
        end
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
        n_vec++;
        if (err_o !== mon_e.err) begin
          n_err++;
          $display("FAIL err_o got %b, required %b", err_o, mon_e.err);
        end
`endif
      end
    end
  end

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() > 0 && cyc < 32) begin
      idle(1'b1);
      cyc++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain pending got %0d, required 0", sb.size());
      sb.delete();
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_drain got %b, required 0", busy);
    end
  endtask

  // Edges from acceptance (counted as 1) until valid_o rises, bounded.
  task automatic measure_latency(input logic [23:0] a, input logic [5:0] b,
                                 input logic [2:0] lvl, input logic [23:0] exp_do,
                                 output int edges);
    drive(1'b1, 1'b1, a, b, lvl, exp_do);
    edges = 1;
    while (!valid_o && edges < 12) begin
      idle(1'b1);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    n_vec++;
    if (dout !== 24'd0) begin n_err++; $display("FAIL reset_do got %0d, required 0", dout); end
    n_vec++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_o got %b, required 0", valid_o); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b, required 0", busy); end
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
    n_vec++;
    if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err_o got %b, required 0", err_o); end
`endif
    n_vec++;
    if (ready_i !== 1'b1) begin n_err++; $display("FAIL ready_i got %b, required 1", ready_i); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int edges;
    measure_latency(24'd1000, 6'd5, 3'd2, 24'd953320, edges);
    n_vec++;
    if (edges !== 4) begin n_err++; $display("FAIL latency got %0d edges, required 4", edges); end
    drain();
  endtask

  task automatic test_boundaries();
    drive(1'b1, 1'b1, 24'd8380416, 6'd15, 3'd3, 24'd7856639);  // wrap
    drive(1'b1, 1'b1, 24'd8380416, 6'd0,  3'd2, 24'd8380416);  // r - r0 = q-1 corner
    drive(1'b1, 1'b1, 24'd0,       6'd43, 3'd2, 24'd8189952);  // largest product
    drive(1'b1, 1'b1, 24'd0,       6'd0,  3'd5, 24'd0);
    drain();
  endtask

  task automatic test_round_trip();
    int r, r0q, r1;
    bit l2;
    for (int i = 0; i < 10000; i++) begin
      r  = int'($urandom_range(TQ - 1, 0));
      l2 = (i % 2) == 0;
      decompose(r, l2, r0q, r1);
      drive(1'b1, 1'b1, 24'(r0q), 6'(r1), l2 ? 3'd2 : 3'd5, 24'(r));
      if (i % 7 == 6) idle(1'b1);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [23:0] held_do;
    logic        held_v;
    logic [23:0] a;
    logic [5:0]  b;
    logic [2:0]  lvl;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        held_do = dout;
        held_v  = valid_o;
        for (int s = 0; s < 3; s++) begin
          drive(1'b1, 1'b0, 24'd77, 6'd1, 3'd2, 24'd0);
          n_vec++;
          if (dout !== held_do) begin
            n_err++;
            $display("FAIL stall_hold_do got %0d, required %0d", dout, held_do);
          end
          n_vec++;
          if (valid_o !== held_v) begin
            n_err++;
            $display("FAIL stall_hold_valid got %b, required %b", valid_o, held_v);
          end
        end
      end
      lvl = (i % 3 == 0) ? 3'd2 : 3'd3;
      a   = 24'($urandom_range(TQ - 1, 0));
      b   = 6'($urandom_range((lvl == 3'd2) ? 43 : 15, 0));
      drive(1'b1, 1'b1, a, b, lvl, model(a, b, lvl));
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    int edges;
    drive(1'b1, 1'b1, 24'd11, 6'd1, 3'd2, model(24'd11, 6'd1, 3'd2));
    drive(1'b1, 1'b1, 24'd22, 6'd2, 3'd2, model(24'd22, 6'd2, 3'd2));
    drive(1'b1, 1'b1, 24'd33, 6'd3, 3'd3, model(24'd33, 6'd3, 3'd3));
    rst = 1'b1;
    idle(1'b0);
    n_vec++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL midreset_valid_o got %b, required 0", valid_o); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %b, required 0", busy); end
    sb.delete();
    rst = 1'b0;
    measure_latency(24'd1000, 6'd5, 3'd2, 24'd953320, edges);
    n_vec++;
    if (edges !== 4) begin n_err++; $display("FAIL post_reset_latency got %0d edges, required 4", edges); end
    drain();
  endtask

`ifdef COEFF_RECOMP_RANGE_CHECK_EN
  task automatic test_range();
    drive(1'b1, 1'b1, 24'd1000,    6'd44, 3'd2, 24'd0);
    drive(1'b1, 1'b1, 24'd1000,    6'd43, 3'd2, model(24'd1000, 6'd43, 3'd2));
    drive(1'b1, 1'b1, 24'd8380417, 6'd0,  3'd2, 24'd0);
    drive(1'b1, 1'b1, 24'd5,       6'd16, 3'd3, 24'd0);
    drive(1'b1, 1'b1, 24'd5,       6'd16, 3'd2, model(24'd5, 6'd16, 3'd2));
    drain();
  endtask
`endif

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    ready_o = 1'b1;
    dia = '0;
    dib = '0;
    sec_lvl = 3'd2;
    test_reset();
    test_latency();
    test_boundaries();
    test_round_trip();
    test_stall();
    test_reset_midstream();
`ifdef COEFF_RECOMP_RANGE_CHECK_EN
    test_range();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
